// File: rtl/inst_sram_responder.sv
// In-order SRAM-like instruction-fetch responder: request queue feeding a single-port RAM access FSM.
// Optional build macro RESP_STALL_EN adds LFSR-driven extra wait cycles before each access.
module inst_sram_responder #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 0,
    parameter int unsigned AW      = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          inst_sram_req,
    input  logic          inst_sram_wr,
    input  logic [1:0]    inst_sram_size,
    input  logic [3:0]    inst_sram_wstrb,
    input  logic [31:0]   inst_sram_addr,
    input  logic [31:0]   inst_sram_wdata,
    output logic          inst_sram_addr_ok,
    output logic          inst_sram_data_ok,
    output logic [31:0]   inst_sram_rdata,
    output logic [3:0]    outstanding,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = 5;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    entry_t        q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    state_t        state;
    state_t        state_n;
    logic [TW-1:0] cnt;
    logic [TW-1:0] cnt_n;
    logic [TW-1:0] wait_total;
    logic          push;
    logic          pop;
    logic          start;
    entry_t        head;
    entry_t        head_n;
    logic          unused_bits;

    assign inst_sram_addr_ok = (count != CW'(DEPTH));
    assign push              = inst_sram_req && inst_sram_addr_ok;
    assign head              = q[rd_ptr];
    // Entry that will sit at the head next cycle; used to load the RAM access registers.
    assign head_n            = pop ? q[rd_ptr + PW'(1)] : head;
    assign outstanding       = 4'(count);
    assign inst_sram_rdata   = (inst_sram_data_ok && !head.wr) ? mem_rdata : 32'h0;
    assign unused_bits       = ^{head_n};

    // Queue storage; payload needs no reset since validity comes from count.
    always_ff @(posedge clk) begin
        if (push) begin
            q[wr_ptr] <= '{wr: inst_sram_wr, size: inst_sram_size, wstrb: inst_sram_wstrb,
                           addr: inst_sram_addr, wdata: inst_sram_wdata};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

`ifdef RESP_STALL_EN
    logic [7:0] lfsr;

    // x^8+x^6+x^5+x^4+1 Fibonacci LFSR, free running.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr <= 8'hA5;
        else         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign wait_total = TW'(LATENCY) + TW'(lfsr[1:0]);
`else
    assign wait_total = TW'(LATENCY);
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop     = 1'b0;
        start   = 1'b0;
        case (state)
            IDLE:   start = (count != '0);
            WAIT:   if (cnt == '0) state_n = ACCESS;
                    else           cnt_n   = cnt - TW'(1);
            ACCESS: state_n = RESP;
            RESP: begin
                pop   = 1'b1;
                start = (count > CW'(1));
                if (!start) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (start) begin
            if (wait_total != '0) begin
                state_n = WAIT;
                cnt_n   = wait_total - TW'(1);
            end else begin
                state_n = ACCESS;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state             <= IDLE;
            cnt               <= '0;
            inst_sram_data_ok <= 1'b0;
            mem_en            <= 1'b0;
            mem_we            <= 4'b0;
            mem_addr          <= '0;
            mem_wdata         <= 32'h0;
        end else begin
            state             <= state_n;
            cnt               <= cnt_n;
            inst_sram_data_ok <= (state_n == RESP);
            mem_en            <= (state_n == ACCESS);
            mem_we            <= (state_n == ACCESS && head_n.wr) ? head_n.wstrb : 4'b0;
            if (state_n == ACCESS) begin
                mem_addr  <= head_n.addr[AW+1:2];
                mem_wdata <= head_n.wdata;
            end
        end
    end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Bench for inst_sram_responder: two configurations share stimulus and are checked against a
// response-schedule model (resp = max(accept+3+L, prev_resp+2+L)) with a byte-accurate memory image.
module tb_inst_sram_responder;

    localparam int unsigned AW = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [1:0]    addr_ok;
    logic [1:0]    data_ok;
    logic [1:0]    mem_en;
    logic [31:0]   rdata     [2];
    logic [3:0]    outst     [2];
    logic [3:0]    mem_we    [2];
    logic [AW-1:0] mem_addr  [2];
    logic [31:0]   mem_wdata [2];
    logic [31:0]   mem_rdata [2];

    typedef struct {
        int          resp;
        bit          wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ent_t;

    ent_t        mq [2][16];
    int          mh [2];
    int          mc [2];
    int          last_resp [2];
    int          lat [2];
    int          dep [2];
    logic [31:0] model_mem [2][256];
    logic [31:0] ram [2][256];
    bit          ram_wr [2][256];
    logic [31:0] ram_cur [2];
    int          t;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    inst_sram_responder #(.DEPTH(4), .LATENCY(0), .AW(AW)) u0 (
        .clk(clk), .resetn(resetn), .inst_sram_req(req), .inst_sram_wr(wr),
        .inst_sram_size(size), .inst_sram_wstrb(wstrb), .inst_sram_addr(addr),
        .inst_sram_wdata(wdata), .inst_sram_addr_ok(addr_ok[0]), .inst_sram_data_ok(data_ok[0]),
        .inst_sram_rdata(rdata[0]), .outstanding(outst[0]), .mem_en(mem_en[0]),
        .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0])
    );

    inst_sram_responder #(.DEPTH(2), .LATENCY(2), .AW(AW)) u1 (
        .clk(clk), .resetn(resetn), .inst_sram_req(req), .inst_sram_wr(wr),
        .inst_sram_size(size), .inst_sram_wstrb(wstrb), .inst_sram_addr(addr),
        .inst_sram_wdata(wdata), .inst_sram_addr_ok(addr_ok[1]), .inst_sram_data_ok(data_ok[1]),
        .inst_sram_rdata(rdata[1]), .outstanding(outst[1]), .mem_en(mem_en[1]),
        .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1])
    );

    function automatic logic [31:0] init_val(input logic [7:0] i);
        case (i)
            8'h00:   return 32'd11;
            8'h01:   return 32'd22;
            8'h02:   return 32'd33;
            8'h08:   return 32'h0;
            8'h10:   return 32'h1234_5678;
            default: return {16'hC0DE, 8'h5A, i};
        endcase
    endfunction

    // Synchronous single-port RAM behind each responder; unwritten words read their preset.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_en[k]) begin
                ram_cur[k] = ram_wr[k][mem_addr[k]] ? ram[k][mem_addr[k]] : init_val(mem_addr[k]);
                mem_rdata[k] <= ram_cur[k];
                for (int b = 0; b < 4; b++)
                    if (mem_we[k][b]) ram_cur[k][8*b +: 8] = mem_wdata[k][8*b +: 8];
                ram[k][mem_addr[k]]    <= ram_cur[k];
                ram_wr[k][mem_addr[k]] <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, t, obs, exp_v);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            mc[k]        = 0;
            mh[k]        = 0;
            last_resp[k] = -100;
        end
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d.rst_data_ok", k), 32'(data_ok[k]), 32'h0);
            chk($sformatf("u%0d.rst_mem_en", k), 32'(mem_en[k]), 32'h0);
            chk($sformatf("u%0d.rst_mem_we", k), 32'(mem_we[k]), 32'h0);
            chk($sformatf("u%0d.rst_outstanding", k), 32'(outst[k]), 32'h0);
            chk($sformatf("u%0d.rst_rdata", k), rdata[k], 32'h0);
            chk($sformatf("u%0d.rst_addr_ok", k), 32'(addr_ok[k]), 32'h1);
        end
    endtask

    // Compare one responder against the model for the current cycle, then advance the model.
    task automatic check_inst(input int k);
        bit          e_dok;
        bit          e_men;
        bit          e_aok;
        ent_t        h;
        logic [31:0] e_rd;
        int          idx;
        h     = mq[k][mh[k]];
        e_aok = mc[k] < dep[k];
        e_dok = mc[k] > 0 && h.resp == t;
        e_men = mc[k] > 0 && h.resp == t + 1;
        idx   = int'(h.addr[9:2]);
        e_rd  = (e_dok && !h.wr) ? model_mem[k][idx] : 32'h0;
        chk($sformatf("u%0d.addr_ok", k), 32'(addr_ok[k]), 32'(e_aok));
        chk($sformatf("u%0d.outstanding", k), 32'(outst[k]), 32'(mc[k]));
        chk($sformatf("u%0d.data_ok", k), 32'(data_ok[k]), 32'(e_dok));
        chk($sformatf("u%0d.rdata", k), rdata[k], e_rd);
        chk($sformatf("u%0d.mem_en", k), 32'(mem_en[k]), 32'(e_men));
        if (e_men) begin
            chk($sformatf("u%0d.mem_addr", k), 32'(mem_addr[k]), 32'(h.addr[9:2]));
            chk($sformatf("u%0d.mem_we", k), 32'(mem_we[k]), h.wr ? 32'(h.wstrb) : 32'h0);
            if (h.wr) begin
                chk($sformatf("u%0d.mem_wdata", k), mem_wdata[k], h.wdata);
                for (int b = 0; b < 4; b++)
                    if (h.wstrb[b]) model_mem[k][idx][8*b +: 8] = h.wdata[8*b +: 8];
            end
        end else begin
            chk($sformatf("u%0d.mem_we_idle", k), 32'(mem_we[k]), 32'h0);
        end
        if (e_dok) begin
            mh[k] = (mh[k] + 1) % 16;
            mc[k]--;
        end
        if (req && e_aok) begin
            ent_t n;
            n.resp  = (t + 3 + lat[k] > last_resp[k] + 2 + lat[k]) ? t + 3 + lat[k]
                                                                   : last_resp[k] + 2 + lat[k];
            n.wr    = wr;
            n.wstrb = wstrb;
            n.addr  = addr;
            n.wdata = wdata;
            last_resp[k] = n.resp;
            mq[k][(mh[k] + mc[k]) % 16] = n;
            mc[k]++;
        end
    endtask

    task automatic step(input bit r, input bit w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d);
        req   = r;
        wr    = w;
        wstrb = s;
        addr  = a;
        wdata = d;
        size  = 2'b10;
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_inst(k);
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Asynchronous reset dropped mid-cycle; outputs must clear before the next edge.
    task automatic do_reset();
        req = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs();
        model_clear();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        t++;
    endtask

    initial begin
        logic [31:0] a;
        lat[0] = 0;
        dep[0] = 4;
        lat[1] = 2;
        dep[1] = 2;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) model_mem[k][i] = init_val(8'(i));
        model_clear();
        req    = 1'b0;
        wr     = 1'b0;
        size   = 2'b10;
        wstrb  = 4'h0;
        addr   = 32'h0;
        wdata  = 32'h0;
        t      = 0;
        resetn = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Isolated read of word 0x10.
        step(1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'h0);
        idle(7);

        // Three back-to-back reads.
        step(1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0);
        step(1'b1, 1'b0, 4'h0, 32'h0000_0004, 32'h0);
        step(1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0);
        idle(10);

        // Sustained requests to fill both queues.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 4'h0, 32'(i * 4), 32'h0);
        idle(30);

        // Partial write followed by a read of the same word.
        step(1'b1, 1'b1, 4'b0011, 32'h0000_0020, 32'hDEAD_BEEF);
        idle(7);
        step(1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0);
        idle(8);

        // Reset while requests are outstanding, then a fresh read.
        step(1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0);
        step(1'b1, 1'b1, 4'hF, 32'h0000_0004, 32'h5555_AAAA);
        step(1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0);
        do_reset();
        idle(10);
        step(1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'h0);
        idle(8);

        // Randomized traffic over a small address window so writes and reads collide.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            a      = $urandom;
            a[9:2] = 8'($urandom_range(0, 15));
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, 4'($urandom), a, $urandom);
        end
        idle(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
